// File: rtl/fv_negacyclic_poly_mult.sv
// Streaming polynomial multiplier c = a*u mod (ring, 2^QW) with valid/ready streams.
// Build with NEGACYCLIC_EN defined for ring X^N+1; otherwise the ring is X^N-1.
module fv_negacyclic_poly_mult #(
  parameter int unsigned N  = 16,
  parameter int unsigned QW = 64,
  parameter int unsigned UW = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          s_u_valid,
  output logic          s_u_ready,
  input  logic [UW:0]   s_u_data,
  input  logic          s_a_valid,
  output logic          s_a_ready,
  input  logic [QW-1:0] s_a_data,
  output logic          m_c_valid,
  input  logic          m_c_ready,
  output logic [QW-1:0] m_c_data,
  output logic          busy,
  output logic          done
);

  localparam int unsigned CW = $clog2(N);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD_U = 2'd1;
  localparam logic [1:0] ST_MAC    = 2'd2;
  localparam logic [1:0] ST_DRAIN  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic [UW:0]   u_q   [N];
  logic [UW:0]   u_d   [N];
  logic [QW-1:0] acc_q [N];
  logic [QW-1:0] acc_d [N];
  logic [QW-1:0] prod  [N];
  logic [CW-1:0] j_idx;
  logic [UW:0]   u_sel;
  logic          last_beat;
  logic          fire;

  assign last_beat = (cnt_q == CW'(N - 1));

  always_comb begin
    fire = 1'b0;
    case (state_q)
      ST_LOAD_U: fire = s_u_valid;
      ST_MAC:    fire = s_a_valid;
      ST_DRAIN:  fire = m_c_ready;
      default:   fire = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD_U;
          cnt_d   = '0;
        end
      end
      ST_LOAD_U, ST_MAC, ST_DRAIN: begin
        if (fire) begin
          // N is a power of two, so the counter wraps to 0 on every phase change
          cnt_d = cnt_q + CW'(1);
          if (last_beat) begin
            state_d = state_q + 2'd1;
            done_d  = (state_q == ST_DRAIN);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    u_d = u_q;
    if (state_q == ST_LOAD_U && s_u_valid) begin
      u_d[cnt_q] = s_u_data;
    end
  end

  // Output slot k receives a_i*u_j with j = (k - i) mod N; k < i means i+j wrapped past N
  always_comb begin
    j_idx = '0;
    u_sel = '0;
    for (int k = 0; k < N; k++) begin
      j_idx   = CW'(k) - cnt_q;
      u_sel   = u_q[j_idx];
      prod[k] = s_a_data * {{(QW-UW-1){u_sel[UW]}}, u_sel};
    end
  end

  always_comb begin
    acc_d = acc_q;
    if (state_q == ST_IDLE && start) begin
      for (int k = 0; k < N; k++) begin
        acc_d[k] = '0;
      end
    end else if (state_q == ST_MAC && s_a_valid) begin
      for (int k = 0; k < N; k++) begin
`ifdef NEGACYCLIC_EN
        if (CW'(k) < cnt_q) begin
          acc_d[k] = acc_q[k] - prod[k];
        end else begin
          acc_d[k] = acc_q[k] + prod[k];
        end
`else
        acc_d[k] = acc_q[k] + prod[k];
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      for (int k = 0; k < N; k++) begin
        u_q[k]   <= '0;
        acc_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      u_q     <= u_d;
      acc_q   <= acc_d;
    end
  end

  assign s_u_ready = (state_q == ST_LOAD_U);
  assign s_a_ready = (state_q == ST_MAC);
  assign m_c_valid = (state_q == ST_DRAIN);
  assign m_c_data  = m_c_valid ? acc_q[cnt_q] : '0;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_fv_negacyclic_poly_mult.sv
// Bench for fv_negacyclic_poly_mult: a small (N=4,QW=8,UW=1) and a large (N=16,QW=64,UW=2)
// instance share one stimulus driver, selected by sel, and are checked against a convolution model.
module tb_fv_negacyclic_poly_mult;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  logic        start = 1'b0;
  logic        u_valid = 1'b0;
  logic        a_valid = 1'b0;
  logic        c_ready = 1'b0;
  logic [2:0]  u_data = '0;
  logic [63:0] a_data = '0;

  logic        u_ready0, a_ready0, c_valid0, busy0, done0;
  logic [7:0]  c_data0;
  logic        u_ready1, a_ready1, c_valid1, busy1, done1;
  logic [63:0] c_data1;

  logic        u_ready, a_ready, c_valid, busy, done;
  logic [63:0] c_data;

  always #5 clk = ~clk;

  fv_negacyclic_poly_mult #(.N(4), .QW(8), .UW(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start & ~sel),
    .s_u_valid(u_valid & ~sel), .s_u_ready(u_ready0), .s_u_data(u_data[1:0]),
    .s_a_valid(a_valid & ~sel), .s_a_ready(a_ready0), .s_a_data(a_data[7:0]),
    .m_c_valid(c_valid0), .m_c_ready(c_ready & ~sel), .m_c_data(c_data0),
    .busy(busy0), .done(done0)
  );

  fv_negacyclic_poly_mult #(.N(16), .QW(64), .UW(2)) dut_l (
    .clk(clk), .rst_n(rst_n), .start(start & sel),
    .s_u_valid(u_valid & sel), .s_u_ready(u_ready1), .s_u_data(u_data),
    .s_a_valid(a_valid & sel), .s_a_ready(a_ready1), .s_a_data(a_data),
    .m_c_valid(c_valid1), .m_c_ready(c_ready & sel), .m_c_data(c_data1),
    .busy(busy1), .done(done1)
  );

  assign u_ready = sel ? u_ready1 : u_ready0;
  assign a_ready = sel ? a_ready1 : a_ready0;
  assign c_valid = sel ? c_valid1 : c_valid0;
  assign busy    = sel ? busy1 : busy0;
  assign done    = sel ? done1 : done0;
  assign c_data  = sel ? c_data1 : {56'd0, c_data0};

  int              errors = 0;
  int              checks = 0;
  longint unsigned exp_q[$];
  int              beats = 0;
  int              done_cnt = 0;
  bit              done_due = 1'b0;
  longint          cyc = 0;
  longint          t_start = 0;
  longint          t_done = 0;
  longint unsigned a_v[16];
  int              u_v[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Compare process: every beat against the model queue, done exactly one cycle after the last beat
  always @(negedge clk) begin
    if (!rst_n) begin
      done_due = 1'b0;
    end else begin
      chk("done_timing", {63'd0, done}, {63'd0, done_due});
      if (done) begin
        done_cnt++;
        t_done = cyc;
      end
      done_due = 1'b0;
      if (c_valid) begin
        if (exp_q.size() == 0) begin
          chk("extra_c_beat", 64'd1, 64'd0);
        end else begin
          chk("c_data", c_data, exp_q[0]);
          if (c_ready) begin
            void'(exp_q.pop_front());
            beats++;
            if (exp_q.size() == 0) done_due = 1'b1;
          end
        end
      end
    end
  end

  // Reference: schoolbook convolution, wrapped terms negated in the negacyclic ring
  task automatic prep(input int n, input int qw);
    longint unsigned c[16];
    longint unsigned t, mask;
    mask = (qw >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << qw) - 64'd1);
    for (int k = 0; k < 16; k++) c[k] = 0;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < n; j++) begin
        t = a_v[i] * longint'(u_v[j]);
`ifdef NEGACYCLIC_EN
        if (i + j >= n) c[(i + j) % n] -= t;
        else c[(i + j) % n] += t;
`else
        c[(i + j) % n] += t;
`endif
      end
    end
    exp_q.delete();
    for (int k = 0; k < n; k++) exp_q.push_back(c[k] & mask);
    beats = 0;
    done_cnt = 0;
  endtask

  task automatic set4(input int u[4], input longint unsigned a[4]);
    for (int k = 0; k < 4; k++) begin
      u_v[k] = u[k];
      a_v[k] = a[k];
    end
  endtask

  task automatic pin4(input longint unsigned l[4]);
    for (int k = 0; k < 4; k++) chk("model_pin", exp_q[k], l[k]);
  endtask

  task automatic rand_data(input int n, input int qw, input int uw);
    int h;
    h = 1 << uw;
    for (int k = 0; k < n; k++) begin
      u_v[k] = int'($urandom_range(0, 2 * h - 1)) - h;
      a_v[k] = {$urandom, $urandom};
      if (qw < 64) a_v[k] = a_v[k] & ((64'd1 << qw) - 64'd1);
    end
  endtask

  // Called at posedge+1; returns at posedge+1
  task automatic go(input int n, input bit gaps, input bit toggle, input bit noise,
                    input int abort_at, input bit time_it);
    int tmo;
    c_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    t_start = cyc;
    for (int j = 0; j < n; j++) begin
      u_valid = 1'b1;
      u_data = 3'(u_v[j]);
      start = noise && (j == 1);
      tmo = 0;
      @(negedge clk);
      while (!u_ready && tmo < 20) begin @(negedge clk); tmo++; end
      if (tmo >= 20) chk("u_ready_timeout", 64'd1, 64'd0);
      @(posedge clk); #1;
      start = 1'b0;
    end
    u_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (abort_at == i) begin
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_u_ready", {63'd0, u_ready}, 64'd0);
        chk("rst_a_ready", {63'd0, a_ready}, 64'd0);
        chk("rst_c_valid", {63'd0, c_valid}, 64'd0);
        chk("rst_c_data", c_data, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        a_valid = 1'b0;
        exp_q.delete();
        return;
      end
      if (gaps) begin
        a_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      a_valid = 1'b1;
      a_data = a_v[i];
      start = noise && (i == 2);
      tmo = 0;
      @(negedge clk);
      while (!a_ready && tmo < 20) begin @(negedge clk); tmo++; end
      if (tmo >= 20) chk("a_ready_timeout", 64'd1, 64'd0);
      @(posedge clk); #1;
      start = 1'b0;
    end
    a_valid = 1'b0;
    start = noise;
    tmo = 0;
    while (beats < n && tmo < 200) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (toggle) c_ready = ~c_ready;
      tmo++;
    end
    if (beats < n) chk("c_timeout", 64'd1, 64'd0);
    c_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin @(posedge clk); #1; end
    chk("c_beats", 64'(beats), 64'(n));
    chk("done_pulses", 64'(done_cnt), 64'd1);
    chk("busy_after", {63'd0, busy}, 64'd0);
    if (time_it) chk("latency", 64'(t_done - t_start), 64'(3 * n));
  endtask

  initial begin
    for (int k = 0; k < 3; k++) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs_s", {58'd0, u_ready0, a_ready0, c_valid0, busy0, done0, |c_data0}, 64'd0);
    chk("reset_outputs_l", {58'd0, u_ready1, a_ready1, c_valid1, busy1, done1, |c_data1}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    set4('{1, 0, 0, 0}, '{5, 6, 7, 8});
    prep(4, 8);
    pin4('{5, 6, 7, 8});
    go(4, 1'b0, 1'b0, 1'b0, -1, 1'b1);

    set4('{0, 1, 0, 0}, '{1, 2, 3, 4});
    prep(4, 8);
`ifdef NEGACYCLIC_EN
    pin4('{252, 1, 2, 3});
`else
    pin4('{4, 1, 2, 3});
`endif
    go(4, 1'b0, 1'b0, 1'b0, -1, 1'b0);

    set4('{-1, 0, 0, 0}, '{1, 2, 3, 4});
    prep(4, 8);
    pin4('{255, 254, 253, 252});
    go(4, 1'b0, 1'b0, 1'b0, -1, 1'b0);

    set4('{1, 1, 1, 1}, '{255, 0, 0, 0});
    prep(4, 8);
    pin4('{255, 255, 255, 255});
    go(4, 1'b0, 1'b0, 1'b0, -1, 1'b0);

    set4('{1, 0, 0, 0}, '{5, 6, 7, 8});
    prep(4, 8);
    go(4, 1'b1, 1'b1, 1'b0, -1, 1'b0);

    prep(4, 8);
    go(4, 1'b0, 1'b0, 1'b0, 2, 1'b0);
    prep(4, 8);
    pin4('{5, 6, 7, 8});
    go(4, 1'b0, 1'b0, 1'b0, -1, 1'b1);

    prep(4, 8);
    go(4, 1'b0, 1'b0, 1'b1, -1, 1'b1);

    for (int r = 0; r < 6; r++) begin
      rand_data(4, 8, 1);
      prep(4, 8);
      go(4, 1'(r % 2), 1'(r / 3), 1'(r % 3 == 1), -1, 1'b0);
    end

    sel = 1'b1;
    @(posedge clk); #1;
    for (int r = 0; r < 4; r++) begin
      rand_data(16, 64, 2);
      prep(16, 64);
      go(16, 1'(r % 2), 1'(r >= 2), 1'(r == 1), -1, 1'(r == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
